modexp_seq: RTL and testbench

//  Sequencer for the parallel square-and-multiply (sam_o) lanes of the modular-exponentiation test datapath.

---
 rtl/modexp_seq.sv | 149 ++++++++++++++
 tb/tb_modexp_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_seq.sv
// modexp_seq: sequencer for the parallel square-and-multiply lanes.
// Latches an exponent and a lane mask when a start request is accepted.
// It then drives one exponent bit per clock, MSB first, and ends the
// operation with a write to the result RAM.
// Build option: define MODEXP_TRACE_EN to write every intermediate z.
// Ports:
//   i_clk, i_rst (async, active-low), i_start, i_abort, i_e, i_lane_mask
//   o_busy, o_done, o_step_en, o_e_bit, o_z_sel_one, o_lane_en
//   o_ram_wren, o_ram_addr, o_step_idx
module modexp_seq #(
    parameter  int EW    = 8,
    parameter  int AW    = 5,
    parameter  int LANES = 2,
    localparam int KW    = (EW > 1) ? $clog2(EW) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [EW-1:0]    i_e,
    input  logic [LANES-1:0] i_lane_mask,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_step_en,
    output logic             o_e_bit,
    output logic             o_z_sel_one,
    output logic [LANES-1:0] o_lane_en,
    output logic             o_ram_wren,
    output logic [AW-1:0]    o_ram_addr,
    output logic [KW-1:0]    o_step_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [KW-1:0] LAST_K = KW'(EW - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    w_bit_idx;
    logic [EW-1:0]    r_e;
    logic [LANES-1:0] r_mask;
    logic [AW-1:0]    r_addr;

    // Step k uses exponent bit EW-1-k, so the MSB goes first.
    assign w_bit_idx  = LAST_K - r_k;
    assign o_ram_addr = r_addr;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_step_en   = 1'b0;
        o_e_bit     = 1'b0;
        o_z_sel_one = 1'b0;
        o_lane_en   = '0;
        o_ram_wren  = 1'b0;
        o_step_idx  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!i_abort && i_start) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end
            end
            S_RUN: begin
                o_busy      = 1'b1;
                o_step_en   = 1'b1;
                o_step_idx  = r_k;
                o_e_bit     = r_e[w_bit_idx];
                o_z_sel_one = (r_k == '0);
                o_lane_en   = r_mask;
`ifdef MODEXP_TRACE_EN
                // Log each intermediate z unless this step is being aborted.
                o_ram_wren  = !i_abort;
`endif
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (r_k == LAST_K) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_busy     = 1'b1;
                o_lane_en  = r_mask;
                // An abort here must not commit a result.
                o_ram_wren = !i_abort;
                w_next     = i_abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (i_start) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_k    <= '0;
            r_e    <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_k    <= '0;
            r_e    <= i_e;
            r_mask <= i_lane_mask;
        end else if (r_state == S_RUN && r_k != LAST_K) begin
            r_k <= r_k + KW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_addr <= '0;
`ifdef MODEXP_TRACE_EN
        end else if (o_ram_wren) begin
            r_addr <= r_addr + AW'(1);
`else
        end else if (r_state == S_DONE) begin
            r_addr <= r_addr + AW'(1);
`endif
        end
    end

endmodule

// File: tb/tb_modexp_seq.sv
// tb_modexp_seq: self-checking bench for modexp_seq.
// Uses table vectors, hand-written corner sequences and random stimulus.
module tb_modexp_seq;

    localparam int EW    = 8;
    localparam int AW    = 5;
    localparam int LANES = 2;
    localparam int KW    = 3;
`ifdef MODEXP_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [EW-1:0]    e;
    logic [LANES-1:0] mask;
    logic             o_busy, o_done, o_step_en, o_e_bit, o_z_sel_one;
    logic [LANES-1:0] o_lane_en;
    logic             o_ram_wren;
    logic [AW-1:0]    o_ram_addr;
    logic [KW-1:0]    o_step_idx;

    int checks = 0;
    int errors = 0;

    // Reference model: ph is the cycle position within an operation.
    // 0 = not active, 1..EW = step cycles, EW+1 = write, EW+2 = done.
    int               ph;
    logic [EW-1:0]    me;
    logic [LANES-1:0] mm;
    int               maddr;

    bit s_busy, s_ebit, s_zsel, s_wren, s_done;

    typedef struct {
        logic [EW-1:0]    e;
        logic [LANES-1:0] m;
        logic [EW-1:0]    seq;
        int               lat;
    } vec_t;
    vec_t tbl[4];

    modexp_seq #(.EW(EW), .AW(AW), .LANES(LANES)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_abort     (abort),
        .i_e         (e),
        .i_lane_mask (mask),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_step_en   (o_step_en),
        .o_e_bit     (o_e_bit),
        .o_z_sel_one (o_z_sel_one),
        .o_lane_en   (o_lane_en),
        .o_ram_wren  (o_ram_wren),
        .o_ram_addr  (o_ram_addr),
        .o_step_idx  (o_step_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        ph    = 0;
        me    = '0;
        mm    = '0;
        maddr = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".done"}, 32'(o_done), 0);
        chk({tag, ".step_en"}, 32'(o_step_en), 0);
        chk({tag, ".e_bit"}, 32'(o_e_bit), 0);
        chk({tag, ".z_sel"}, 32'(o_z_sel_one), 0);
        chk({tag, ".lane_en"}, 32'(o_lane_en), 0);
        chk({tag, ".wren"}, 32'(o_ram_wren), 0);
        chk({tag, ".addr"}, 32'(o_ram_addr), 0);
        chk({tag, ".step_idx"}, 32'(o_step_idx), 0);
    endtask

    // One clock: drive inputs, compare against the model, advance the model.
    task automatic cycle(input logic st, input logic ab,
                         input logic [EW-1:0] ev,
                         input logic [LANES-1:0] mv);
        bit run, bsy, wr;
        int eb;
        start = st;
        abort = ab;
        e     = ev;
        mask  = mv;
        #1;
        run = (ph >= 1 && ph <= EW);
        bsy = (ph >= 1 && ph <= EW + 1);
        wr  = TRACE ? (bsy && !ab) : (ph == EW + 1 && !ab);
        eb  = run ? int'(me[EW-ph]) : 0;
        chk("busy", 32'(o_busy), 32'(bsy));
        chk("done", 32'(o_done), 32'(ph == EW + 2));
        chk("step_en", 32'(o_step_en), 32'(run));
        chk("e_bit", 32'(o_e_bit), eb);
        chk("z_sel", 32'(o_z_sel_one), 32'(ph == 1));
        chk("lane_en", 32'(o_lane_en), bsy ? 32'(mm) : 0);
        chk("wren", 32'(o_ram_wren), 32'(wr));
        chk("addr", 32'(o_ram_addr), maddr);
        chk("step_idx", 32'(o_step_idx), run ? ph - 1 : 0);
        s_busy = o_busy;
        s_ebit = o_e_bit;
        s_zsel = o_z_sel_one;
        s_wren = o_ram_wren;
        s_done = o_done;
        @(posedge clk);
        if (!TRACE && ph == EW + 2) maddr = (maddr + 1) % (1 << AW);
        if (TRACE && wr) maddr = (maddr + 1) % (1 << AW);
        if (ab) begin
            ph = 0;
        end else if (ph == 0 || ph == EW + 2) begin
            if (st) begin
                ph = 1;
                me = ev;
                mm = mv;
            end else begin
                ph = 0;
            end
        end else begin
            ph++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [EW-1:0] seq;
        int dcyc, wfirst, wcnt, zc, dones, bcnt;

        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        e     = '0;
        mask  = '0;
        model_reset();
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        tbl[0] = '{e: 8'h0F, m: 2'b11, seq: 8'b0000_1111, lat: 10};
        tbl[1] = '{e: 8'h00, m: 2'b01, seq: 8'b0000_0000, lat: 10};
        tbl[2] = '{e: 8'hFF, m: 2'b10, seq: 8'b1111_1111, lat: 10};
        tbl[3] = '{e: 8'hA5, m: 2'b00, seq: 8'b1010_0101, lat: 10};

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, tbl[i].e, tbl[i].m);
            seq    = '0;
            dcyc   = -1;
            wfirst = -1;
            wcnt   = 0;
            zc     = 0;
            for (int j = 1; j <= EW + 2; j++) begin
                cycle(1'b0, 1'b0, EW'($urandom), tbl[i].m);
                if (j <= EW) seq[EW-j] = s_ebit;
                if (s_zsel) zc++;
                if (s_wren) begin
                    wcnt++;
                    if (wfirst < 0) wfirst = j;
                end
                if (s_done && dcyc < 0) dcyc = j;
            end
            chk("tbl.seq", 32'(seq), 32'(tbl[i].seq));
            chk("tbl.latency", dcyc, tbl[i].lat);
            chk("tbl.wfirst", wfirst, TRACE ? 1 : EW + 1);
            chk("tbl.wcnt", wcnt, TRACE ? EW + 1 : 1);
            chk("tbl.zsel", zc, 1);
        end

        // start held high: back-to-back ops, address wraps, e changes ignored.
        dones = 0;
        for (int i = 0; i < 331; i++) begin
            cycle(1'b1, 1'b0, EW'($urandom), LANES'($urandom));
            if (s_done) dones++;
        end
        chk("held.dones", dones, 33);
        cycle(1'b0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, '0, '0);

        // abort at T+4.
        cycle(1'b1, 1'b0, 8'h3C, 2'b11);
        for (int j = 1; j <= 3; j++) cycle(1'b0, 1'b0, 8'h00, 2'b00);
        cycle(1'b0, 1'b1, 8'h00, 2'b00);
        dones = 0;
        bcnt  = 0;
        for (int j = 0; j < 12; j++) begin
            cycle(1'b0, 1'b0, 8'h00, 2'b00);
            if (s_done) dones++;
            if (s_busy) bcnt++;
        end
        chk("abort.dones", dones, 0);
        chk("abort.busy", bcnt, 0);

        // abort during the write cycle.
        cycle(1'b1, 1'b0, 8'h81, 2'b01);
        for (int j = 1; j <= EW; j++) cycle(1'b0, 1'b0, 8'h00, 2'b01);
        cycle(1'b0, 1'b1, 8'h00, 2'b01);
        cycle(1'b0, 1'b0, 8'h00, 2'b01);
        chk("abortw.done", 32'(s_done), 0);

        // abort with start in IDLE stays idle.
        cycle(1'b1, 1'b1, 8'h55, 2'b11);
        cycle(1'b0, 1'b0, 8'h00, 2'b00);
        chk("abort_idle.busy", 32'(s_busy), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(3) == 0, $urandom_range(19) == 0,
                  EW'($urandom), LANES'($urandom));
        end

        // Reset in the middle of RUN.
        cycle(1'b1, 1'b0, 8'hC3, 2'b11);
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 8'h00, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 8'h00, 2'b00);
        cycle(1'b1, 1'b0, 8'h96, 2'b10);
        for (int j = 1; j <= EW + 3; j++) cycle(1'b0, 1'b0, 8'h00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
